// File: rtl/corelet_pkg.sv
// Shared types for the corelet sequencer: FSM states, array instruction encoding
// and the counter-width helper.
package corelet_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, KERNEL, LOAD_A, EXEC, DRAIN, DONE
    } state_e;

    localparam int INST_W        = 2;
    localparam int INST_LOAD_BIT = 0;
    localparam int INST_EXEC_BIT = 1;

    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t INST_NONE = 2'b00;
    localparam inst_t INST_LOAD = 2'b01;
    localparam inst_t INST_EXEC = 2'b10;

    // Wide enough for num_vec + ROW + COL - 1 at the largest num_vec.
    function automatic int cnt_width(int len_w, int row, int col);
        return $clog2((1 << len_w) + row + col + 1);
    endfunction

endpackage

// File: rtl/corelet_seq_if.sv
// Control/handshake bundle between the corelet sequencer and its SRAM, L0,
// PE array and output FIFO.
interface corelet_seq_if #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
);
    logic              start;
    logic              mode;
    logic [LEN_W-1:0]  num_vec;
    logic [ADDR_W-1:0] base_addr;
    logic              l0_full;
    logic              ofifo_valid;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              l0_wr;
    logic              inst_load;
    logic              inst_exec;
    logic              ofifo_rd;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, num_vec, base_addr, l0_full, ofifo_valid,
        input  mem_rd, mem_addr, l0_wr, inst_load, inst_exec, ofifo_rd, busy, done
    );

    modport slave (
        input  start, mode, num_vec, base_addr, l0_full, ofifo_valid,
        output mem_rd, mem_addr, l0_wr, inst_load, inst_exec, ofifo_rd, busy, done
    );
endinterface

// File: rtl/seq_rd_issuer.sv
// Stall-aware SRAM read issuer: streams a burst of contiguous reads into L0,
// holding off while L0 is almost full; each read lands in L0 one cycle later.
module seq_rd_issuer #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld,
    input  logic [CNT_W-1:0]  ld_cnt,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              l0_full,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              l0_wr,
    output logic              last_wr
);
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              l0_wr_q, l0_wr_d;

    assign mem_rd   = (rem_q != '0) && !l0_full;
    assign mem_addr = addr_q;
    assign l0_wr    = l0_wr_q;
    // The final L0 write is the one that follows the read that emptied the burst.
    assign last_wr  = l0_wr_q && (rem_q == '0);

    always_comb begin
        rem_d   = rem_q;
        addr_d  = addr_q;
        l0_wr_d = mem_rd;
        if (ld) begin
            rem_d  = ld_cnt;
            addr_d = ld_base;
        end else if (mem_rd) begin
            rem_d  = rem_q - CNT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            addr_q  <= '0;
            l0_wr_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            l0_wr_q <= l0_wr_d;
        end
    end
endmodule

// File: rtl/corelet_seq.sv
// Corelet sequencer: loads a weight kernel, streams activations, runs the PE
// array and drains the output FIFO for one start request.
module corelet_seq
    import corelet_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
) (
    input logic           clk,
    input logic           reset,
    corelet_seq_if.slave  bus
);
    localparam int CNT_W = cnt_width(LEN_W, ROW, COL);
    localparam logic [CNT_W-1:0] FILL = CNT_W'(ROW + COL - 1);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [LEN_W-1:0]  nv_q, nv_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [LEN_W-1:0]  pop_q, pop_d;
    inst_t             inst_q, inst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ld;
    logic [CNT_W-1:0]  ld_cnt;
    logic [ADDR_W-1:0] ld_base;
    logic              last_wr;

    seq_rd_issuer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rd (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .ld_cnt   (ld_cnt),
        .ld_base  (ld_base),
        .l0_full  (bus.l0_full),
        .mem_rd   (bus.mem_rd),
        .mem_addr (bus.mem_addr),
        .l0_wr    (bus.l0_wr),
        .last_wr  (last_wr)
    );

    assign bus.ofifo_rd  = (state_q == DRAIN) && bus.ofifo_valid && (pop_q != nv_q);
    assign bus.inst_load = inst_q[INST_LOAD_BIT];
    assign bus.inst_exec = inst_q[INST_EXEC_BIT];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        nv_d    = nv_q;
        base_d  = base_q;
        cyc_d   = cyc_q;
        pop_d   = pop_q;
        ld      = 1'b0;
        ld_cnt  = '0;
        ld_base = base_q;
        case (state_q)
            IDLE: if (bus.start) begin
                mode_d  = bus.mode;
                nv_d    = bus.num_vec;
                base_d  = bus.base_addr;
                ld_base = bus.base_addr;
                if (!bus.mode) begin
                    state_d = LOAD_W;
                    ld      = 1'b1;
                    ld_cnt  = CNT_W'(COL);
                end else if (bus.num_vec == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD_A;
                    ld      = 1'b1;
                    ld_cnt  = CNT_W'(bus.num_vec);
                end
            end
            LOAD_W: if (last_wr) begin
                state_d = KERNEL;
                cyc_d   = FILL;
            end
            KERNEL: if (cyc_q == CNT_W'(1)) begin
                if (nv_q == '0) begin
                    state_d = DONE;
                end else begin
                    // Activations sit directly after the weight kernel.
                    state_d = LOAD_A;
                    ld      = 1'b1;
                    ld_cnt  = CNT_W'(nv_q);
                    ld_base = mode_q ? base_q : base_q + ADDR_W'(COL);
                end
            end else begin
                cyc_d = cyc_q - CNT_W'(1);
            end
            LOAD_A: if (last_wr) begin
                state_d = EXEC;
                cyc_d   = CNT_W'(nv_q) + FILL;
            end
            EXEC: if (cyc_q == CNT_W'(1)) begin
                state_d = DRAIN;
                pop_d   = '0;
            end else begin
                cyc_d = cyc_q - CNT_W'(1);
            end
            DRAIN: if (bus.ofifo_rd) begin
                pop_d = pop_q + LEN_W'(1);
                if (pop_q + LEN_W'(1) == nv_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inst_d = (state_d == KERNEL) ? INST_LOAD :
                 (state_d == EXEC)   ? INST_EXEC : INST_NONE;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            nv_q    <= '0;
            base_q  <= '0;
            cyc_q   <= '0;
            pop_q   <= '0;
            inst_q  <= INST_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            nv_q    <= nv_d;
            base_q  <= base_d;
            cyc_q   <= cyc_d;
            pop_q   <= pop_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: stimulus queues the expected reads, run
// lengths, pops and latency per request; a negedge monitor checks them.
module tb_corelet_seq;
    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 8;
    localparam int AMASK  = (1 << ADDR_W) - 1;
    localparam int WDOG   = 1500;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    corelet_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    corelet_seq #(.ROW(ROW), .COL(COL), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_load[$];
    int exp_exec[$];
    int exp_pops[$];
    int exp_lat[$];
    int full_mode = 0;
    int valid_mode = 0;

    int load_run = 0, exec_run = 0, pops = 0, lat = 0;
    bit armed = 1'b0;
    logic prev_rd = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outs", int'({bus.mem_rd, bus.l0_wr, bus.inst_load, bus.inst_exec,
                                    bus.ofifo_rd, bus.busy, bus.done, bus.mem_addr}), 0);
            load_run = 0; exec_run = 0; pops = 0; armed = 1'b0; prev_rd = 1'b0;
        end else begin
            if (armed) lat++;
            if (bus.start && !bus.busy) begin
                armed = 1'b1; lat = -1; pops = 0;
            end
            chk("busy", int'(bus.busy), (armed && lat >= 0) ? 1 : 0);
            chk("l0_wr_lag", int'(bus.l0_wr), int'(prev_rd));
            chk("load_exec_excl", int'(bus.inst_load && bus.inst_exec), 0);
            if (bus.l0_full) chk("rd_while_full", int'(bus.mem_rd), 0);
            if (bus.ofifo_rd) begin
                chk("pop_wo_valid", int'(bus.ofifo_valid), 1);
                pops++;
            end
            if (bus.mem_rd) begin
                if (exp_addr.size() == 0) chk("unexp_rd", int'(bus.mem_addr), -1);
                else chk("rd_addr", int'(bus.mem_addr), exp_addr.pop_front());
            end
            if (bus.inst_load) load_run++;
            else if (load_run > 0) begin
                if (exp_load.size() == 0) chk("unexp_load", load_run, 0);
                else chk("load_len", load_run, exp_load.pop_front());
                load_run = 0;
            end
            if (bus.inst_exec) exec_run++;
            else if (exec_run > 0) begin
                if (exp_exec.size() == 0) chk("unexp_exec", exec_run, 0);
                else chk("exec_len", exec_run, exp_exec.pop_front());
                exec_run = 0;
            end
            if (bus.done) begin
                if (exp_pops.size() == 0) chk("unexp_done", 1, 0);
                else begin
                    int e;
                    chk("pops", pops, exp_pops.pop_front());
                    chk("rd_left", exp_addr.size(), 0);
                    chk("load_left", exp_load.size(), 0);
                    chk("exec_left", exp_exec.size(), 0);
                    e = exp_lat.pop_front();
                    if (e >= 0) chk("latency", lat, e);
                end
                armed = 1'b0;
            end
            if (armed && lat > WDOG) begin
                chk("timeout", lat, WDOG);
                armed = 1'b0;
            end
            prev_rd = bus.mem_rd;
        end
    end

    // L0 back-pressure and output-FIFO occupancy drivers
    always @(posedge clk) begin
        #1;
        case (full_mode)
            0:       bus.l0_full = 1'b0;
            1:       bus.l0_full = ($urandom_range(0, 3) == 0);
            default: bus.l0_full = armed && lat >= 3 && lat <= 5;
        endcase
        case (valid_mode)
            0:       bus.ofifo_valid = 1'b1;
            1:       bus.ofifo_valid = ~bus.ofifo_valid;
            default: bus.ofifo_valid = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Cycles from the accepting edge to the done cycle, no stalls, FIFO always valid.
    function automatic int ideal_lat(input bit m, input int nv);
        int l = 0;
        if (!m) l += (COL + 1) + (ROW + COL - 1);
        if (nv > 0) l += (nv + 1) + (nv + ROW + COL - 1) + nv;
        return l;
    endfunction

    task automatic begin_txn(input bit m, input int nv, input int base);
        int first;
        if (!m) for (int i = 0; i < COL; i++) exp_addr.push_back((base + i) & AMASK);
        first = m ? base : base + COL;
        for (int i = 0; i < nv; i++) exp_addr.push_back((first + i) & AMASK);
        if (!m) exp_load.push_back(ROW + COL - 1);
        if (nv > 0) exp_exec.push_back(nv + ROW + COL - 1);
        exp_pops.push_back(nv);
        exp_lat.push_back((full_mode == 0 && valid_mode == 0) ? ideal_lat(m, nv) : -1);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = m;
        bus.num_vec = LEN_W'(nv); bus.base_addr = ADDR_W'(base);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_txn(input bit poke_done);
        for (int c = 0; c < 2000 && !bus.done; c++) @(negedge clk);
        if (poke_done && bus.done) begin
            bus.start = 1'b1; bus.mode = 1'b1; bus.num_vec = '0;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_addr.delete(); exp_load.delete(); exp_exec.delete();
        exp_pops.delete(); exp_lat.delete();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.num_vec = '0; bus.base_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        begin_txn(1'b0, 4, 'h010); finish_txn(1'b0);
        full_mode = 2;
        begin_txn(1'b0, 4, 'h100); finish_txn(1'b0);
        full_mode = 0;
        begin_txn(1'b1, 0, 'h055); finish_txn(1'b1);
        begin_txn(1'b0, 0, 'h200); finish_txn(1'b0);
        begin_txn(1'b0, 3, 'h7FE); finish_txn(1'b0);

        // Abort during EXEC, then a clean run.
        begin_txn(1'b0, 4, 'h020);
        for (int c = 0; c < 200 && !bus.inst_exec; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (5) @(posedge clk);
        begin_txn(1'b0, 4, 'h010); finish_txn(1'b0);

        // Abort right after a read issues: its L0 write must not appear.
        begin_txn(1'b1, 6, 'h300);
        for (int c = 0; c < 50 && !bus.mem_rd; c++) @(negedge clk);
        @(negedge clk);
        do_reset();
        repeat (5) @(posedge clk);

        // start during DRAIN and in DONE, FIFO valid every other cycle.
        valid_mode = 1;
        begin_txn(1'b0, 5, 'h040);
        for (int c = 0; c < 300 && !bus.ofifo_rd; c++) @(negedge clk);
        #1 bus.start = 1'b1; bus.mode = 1'b0; bus.num_vec = LEN_W'(2);
        @(posedge clk); #1 bus.start = 1'b0;
        finish_txn(1'b1);
        repeat (20) @(posedge clk);
        valid_mode = 0;

        for (int t = 0; t < 12; t++) begin
            full_mode  = int'($urandom_range(0, 1));
            valid_mode = int'($urandom_range(0, 2));
            begin_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                      int'($urandom_range(0, AMASK)));
            finish_txn(1'b0);
        end
        full_mode = 0; valid_mode = 0;
        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
